accumulate_unit: RTL and testbench
==================================

Name: accumulate_unit

Overview:
- Sequential consumer stage placed directly downstream of the 4-bit ripple-carry adding datapath.
- Captures operands through a valid/ready handshake and adds each one into a registered accumulator using an internal ripple-carry chain.
- Presents each result together with carry and signed-overflow flags through an output valid/ready handshake.
- Turns the lab's combinational adder into a running-sum unit that the display/controller stage can drive.

Parameters:
- WIDTH, 4, accumulator and operand width in bits.
- CNT_W, 4, width of the accepted-operation counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  1  0 = ADD (acc + in_data + in_cin), 1 = LOAD (acc = in_data).
- in_data  input  WIDTH  operand.
- in_cin  input  1  carry-in for ADD; ignored for LOAD.
- out_valid  output  1  result available; high only in HOLD.
- out_ready  input  1  consumer takes the result.
- acc_out  output  WIDTH  accumulator value, always driven from the register.
- cout  output  1  carry-out of the last ADD; 0 after LOAD.
- ovf  output  1  signed (two's complement) overflow of the last ADD; 0 after LOAD.
- op_count  output  CNT_W  number of accepted operations since reset.

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high, sampled on the rising clk edge.
  - State goes to IDLE.
  - acc_out = 0, cout = 0, ovf = 0, op_count = 0.
  - in_ready = 1 and out_valid = 0 from the first edge after reset deasserts.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - in_ready = 1.
  - When in_valid = 1, latch in_op, in_data and in_cin, increment op_count, and go to EXEC.
  - When in_valid = 0, stay in IDLE.
- EXEC (exactly one cycle, in_ready = 0):
  - ADD: register the sum from the ripple chain. acc <= (acc + in_data + in_cin) mod 2^WIDTH.
  - ADD flags: cout <= carry out of the MSB. ovf <= carry into MSB XOR carry out of MSB.
  - LOAD: acc <= in_data, cout <= 0, ovf <= 0.
  - Go to HOLD.
- HOLD:
  - out_valid = 1.
  - acc_out, cout and ovf stay stable until the handshake completes.
  - When out_ready = 1, go to IDLE. When out_ready = 0, stay in HOLD.
- Latency: from the in_valid & in_ready edge to out_valid is 2 cycles. The minimum accept-to-accept period is 3 cycles.
- Simultaneous events: in_valid is ignored outside IDLE; the operand must be held by the producer until it is accepted.
- out_ready is ignored outside HOLD.
- Reset takes priority over everything. Reset asserted in EXEC or HOLD discards the in-flight result with no out_valid pulse.
- Wrap-around:
  - op_count wraps from 2^CNT_W-1 to 0 silently.
  - The accumulator wraps modulo 2^WIDTH unless saturation is compiled in.
- Flags always describe only the most recent completed operation.

Optional Feature:
- Macro: ACCUMULATE_UNIT_SATURATE_EN.
- Defined: an ADD that produces unsigned carry-out sets acc to all ones (2^WIDTH-1). cout = 1 is still reported; ovf is computed as normal.
- Not defined: modular wrap as described above.

Decomposition:
- Package accumulate_pkg:
  - State enum (IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2).
  - Op encoding constants OP_ADD = 1'b0, OP_LOAD = 1'b1.
  - Default WIDTH/CNT_W constants.
- One sub-module: ripple_add_n, parameterised by WIDTH.
  - Purely combinational chain of bit-level full adders.
  - Outputs: sum[WIDTH-1:0], c_msb_in, c_out.
  - Instantiated once; the FSM, registers and counter live in accumulate_unit.

Test Plan:
- Reset, then LOAD 4'h3, then ADD 4'h4 with cin = 0 -> acc_out = 4'h7, cout = 0, ovf = 0, op_count = 2; out_valid appears 2 cycles after each accept.
- acc = 4'hF, ADD 4'h1 with cin = 0 -> acc_out = 4'h0, cout = 1, ovf = 0 (with ACCUMULATE_UNIT_SATURATE_EN: acc_out = 4'hF, cout = 1).
- acc = 4'h7, ADD 4'h1 -> acc_out = 4'h8, cout = 0, ovf = 1; then ADD 4'h8 with cin = 1 -> acc_out = 4'h1, cout = 1, ovf = 1.
- Hold out_ready = 0 for 5 cycles in HOLD while toggling in_valid and in_data -> out_valid stays 1, in_ready stays 0, acc_out stays stable, no extra op_count increment.
- Assert reset during EXEC of an ADD 4'h5 -> next cycle acc_out = 0, op_count = 0, out_valid = 0, in_ready = 1.
- Perform 17 back-to-back LOAD 4'h0 operations (CNT_W = 4) -> op_count reads 1 after the 17th accept.

Source files
------------

// File: rtl/accumulate_pkg.sv
// Shared types and constants for the accumulate unit: FSM encoding, op codes and default sizes.
package accumulate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  localparam int ACC_WIDTH_DEF = 4;
  localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/accumulate_unit_ripple_add_n.sv
// Combinational ripple-carry adder built from bit-level full adders.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module ripple_add_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_msb_in_o,
  output logic             c_out_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_msb_in_o = carry[WIDTH-1];
  assign c_out_o    = carry[WIDTH];

endmodule

// File: rtl/accumulate_unit.sv
// Running-sum unit with in/out valid-ready handshakes around a ripple-carry adder.
// Optional build macro ACCUMULATE_UNIT_SATURATE_EN clamps the accumulator to all ones on carry-out.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// EXEC  | one cycle: apply latched ADD/LOAD to the accumulator
// HOLD  | result presented with out_valid until out_ready
module accumulate_unit
  import accumulate_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             cout,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cin_q, cin_d;

  logic [WIDTH-1:0] sum;
  logic             c_msb_in;
  logic             c_out;

  ripple_add_n #(.WIDTH(WIDTH)) u_add (
    .a_i        (acc_q),
    .b_i        (data_q),
    .cin_i      (cin_q),
    .sum_o      (sum),
    .c_msb_in_o (c_msb_in),
    .c_out_o    (c_out)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    cin_d   = cin_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          data_d  = in_data;
          cin_d   = in_cin;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_LOAD) begin
          acc_d  = data_q;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end else begin
`ifdef ACCUMULATE_UNIT_SATURATE_EN
          acc_d  = c_out ? {WIDTH{1'b1}} : sum;
`else
          acc_d  = sum;
`endif
          cout_d = c_out;
          ovf_d  = c_msb_in ^ c_out;
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      data_q  <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cin_q   <= cin_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign acc_out   = acc_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_accumulate_unit.sv
// Self-checking bench for accumulate_unit: directed scenarios plus random ops against an arithmetic model.
module tb_accumulate_unit;

  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int MODV = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_op = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  acc_out;
  logic          cout;
  logic          ovf;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;

  int m_acc = 0;
  int m_cout = 0;
  int m_ovf = 0;
  int m_cnt = 0;

  accumulate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .cout      (cout),
    .ovf       (ovf),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from two's complement range.
  task automatic model_apply(input logic op, input int data, input int cin);
    int s, sa, sd, ss;
    m_cnt = (m_cnt + 1) % (1 << CW);
    if (op) begin
      m_acc = data; m_cout = 0; m_ovf = 0;
    end else begin
      s  = m_acc + data + cin;
      sa = (m_acc >= MODV/2) ? m_acc - MODV : m_acc;
      sd = (data  >= MODV/2) ? data  - MODV : data;
      ss = sa + sd + cin;
      m_cout = (s >= MODV) ? 1 : 0;
      m_ovf  = (ss > MODV/2 - 1 || ss < -(MODV/2)) ? 1 : 0;
`ifdef ACCUMULATE_UNIT_SATURATE_EN
      m_acc = m_cout ? MODV - 1 : s % MODV;
`else
      m_acc = s % MODV;
`endif
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_acc"},  32'(acc_out),  32'(m_acc));
    chk({tag, "_cout"}, 32'(cout),     32'(m_cout));
    chk({tag, "_ovf"},  32'(ovf),      32'(m_ovf));
    chk({tag, "_cnt"},  32'(op_count), 32'(m_cnt));
  endtask

  // Called at a negedge with the unit in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input string tag, input logic op, input logic [W-1:0] data,
                       input logic cin, input int hold);
    in_valid = 1'b1; in_op = op; in_data = data; in_cin = cin;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    model_apply(op, int'(data), int'(cin));
    @(negedge clk);
    chk({tag, "_exec_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_exec_in_ready"},  32'(in_ready),  32'd0);
    in_valid = 1'($urandom); in_data = W'($urandom); in_op = 1'($urandom); in_cin = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
    chk_result(tag);
    for (int k = 0; k < hold; k++) begin
      in_valid = ~in_valid; in_data = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_stall_acc"},       32'(acc_out),   32'(m_acc));
      chk({tag, "_stall_cnt"},       32'(op_count),  32'(m_cnt));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_done_acc"},       32'(acc_out),   32'(m_acc));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_acc = 0; m_cout = 0; m_ovf = 0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_result("rst");
  endtask

  initial begin
    do_reset();

    do_op("load3", 1'b1, 4'h3, 1'b0, 0);
    do_op("add4",  1'b0, 4'h4, 1'b0, 0);
    chk("tp1_acc", 32'(acc_out), 32'h7);
    chk("tp1_cnt", 32'(op_count), 32'd2);

    do_op("loadF", 1'b1, 4'hF, 1'b0, 0);
    do_op("addF1", 1'b0, 4'h1, 1'b0, 0);
`ifdef ACCUMULATE_UNIT_SATURATE_EN
    chk("tp2_acc", 32'(acc_out), 32'hF);
`else
    chk("tp2_acc", 32'(acc_out), 32'h0);
`endif
    chk("tp2_cout", 32'(cout), 32'd1);
    chk("tp2_ovf",  32'(ovf),  32'd0);

    do_op("load7", 1'b1, 4'h7, 1'b0, 0);
    do_op("add71", 1'b0, 4'h1, 1'b0, 0);
    chk("tp3a_acc",  32'(acc_out), 32'h8);
    chk("tp3a_cout", 32'(cout), 32'd0);
    chk("tp3a_ovf",  32'(ovf),  32'd1);
    do_op("add8c", 1'b0, 4'h8, 1'b1, 5);
`ifdef ACCUMULATE_UNIT_SATURATE_EN
    chk("tp3b_acc",  32'(acc_out), 32'hF);
`else
    chk("tp3b_acc",  32'(acc_out), 32'h1);
`endif
    chk("tp3b_cout", 32'(cout), 32'd1);
    chk("tp3b_ovf",  32'(ovf),  32'd1);

    // Reset arriving during EXEC must drop the in-flight ADD.
    in_valid = 1'b1; in_op = 1'b0; in_data = 4'h5; in_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rexec_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_acc = 0; m_cout = 0; m_ovf = 0; m_cnt = 0;
    chk("rexec_acc",       32'(acc_out),   32'd0);
    chk("rexec_cnt",       32'(op_count),  32'd0);
    chk("rexec_out_valid", 32'(out_valid), 32'd0);
    chk("rexec_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rexec_after_out_valid", 32'(out_valid), 32'd0);
    chk_result("rexec_after");

    for (int n = 0; n < 40; n++)
      do_op("rand", 1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    do_reset();
    for (int n = 0; n < 17; n++)
      do_op("wrap", 1'b1, 4'h0, 1'b0, 0);
    chk("wrap_cnt", 32'(op_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
